// File: rtl/acc_drain_buffer.sv
// acc_drain_buffer: row FIFO draining deskewed accumulator rows as a framed stream; DRAIN_RELU_EN clamps negative outputs to zero
module acc_drain_buffer #(
   parameter int acc_width       = 8,
   parameter int systolic_column = 16,
   parameter int fifo_depth      = 8,
   parameter int row_cnt_width   = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [row_cnt_width-1:0]             tile_rows,
   output logic                                 busy,
   input  logic                                 in_valid,
   input  logic [acc_width*systolic_column-1:0] in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [acc_width*systolic_column-1:0] out_data,
   output logic                                 out_last,
   output logic                                 done,
   output logic                                 overflow,
   output logic                                 stray
);
   localparam int dw = acc_width * systolic_column;
   localparam int aw = $clog2(fifo_depth);
   localparam logic [aw:0] full_cnt = (aw + 1)'(fifo_depth);
   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
   state_t state;
   logic [dw-1:0] mem [fifo_depth];
   logic [dw-1:0] head, head_act;
   logic [aw-1:0] wr_ptr, rd_ptr;
   logic [aw:0] count;
   logic [row_cnt_width-1:0] rows_q, in_cnt, out_cnt, dropped;
   logic want, pop, push, drop, stray_ev, all_dropped;

   assign busy      = state == COLLECT;
   assign done      = state == DONE;
   assign out_valid = count != '0;
   assign head      = mem[rd_ptr];
   assign want      = busy && in_valid && in_cnt < rows_q;
   assign pop       = out_valid && out_ready;
   assign push      = want && (count != full_cnt || pop);
   assign drop      = want && !push;
   assign stray_ev  = in_valid && !want;
   // dropped rows shorten the tile, so the last surviving row is still marked
   assign out_last  = out_valid && out_cnt == rows_q - row_cnt_width'(1) - dropped;
   assign all_dropped = in_cnt == rows_q && !out_valid && dropped == rows_q;
   assign out_data  = out_valid ? head_act : '0;

`ifdef DRAIN_RELU_EN
   for (genvar i = 0; i < systolic_column; i++) begin : g_relu
      assign head_act[acc_width*i +: acc_width] =
         head[acc_width*(i+1)-1] ? '0 : head[acc_width*i +: acc_width];
   end
`else
   assign head_act = head;
`endif

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= in_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rows_q   <= '0;
         in_cnt   <= '0;
         out_cnt  <= '0;
         dropped  <= '0;
         overflow <= 1'b0;
         stray    <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + aw'(push);
         rd_ptr <= rd_ptr + aw'(pop);
         count  <= count + (aw + 1)'(push) - (aw + 1)'(pop);
         if (state == IDLE && start) begin
            rows_q   <= tile_rows;
            in_cnt   <= '0;
            out_cnt  <= '0;
            dropped  <= '0;
            overflow <= 1'b0;
            stray    <= stray_ev;
            state    <= tile_rows == '0 ? DONE : COLLECT;
         end else begin
            in_cnt   <= in_cnt + row_cnt_width'(want);
            out_cnt  <= out_cnt + row_cnt_width'(pop);
            dropped  <= dropped + row_cnt_width'(drop);
            overflow <= overflow | drop;
            stray    <= stray | stray_ev;
            state    <= state == DONE ? IDLE :
                        (busy && ((pop && out_last) || all_dropped)) ? DONE : state;
         end
      end
   end
endmodule

// File: tb/tb_acc_drain_buffer.sv
// tb_acc_drain_buffer: scoreboard bench for acc_drain_buffer
module tb_acc_drain_buffer;
   localparam int AW = 8, COLS = 16, DW = AW * COLS;
   logic clk = 1'b0;
   logic rst, start, busy, in_valid, out_valid, out_ready, out_last, done, overflow, stray;
   logic [7:0] tile_rows;
   logic [DW-1:0] in_data, out_data;
   logic [DW-1:0] q_data[$];
   logic q_last[$];
   int checks = 0, errors = 0, out_rows = 0, base = 0;

   always #5 clk = ~clk;

   acc_drain_buffer dut (
      .clk(clk), .rst(rst), .start(start), .tile_rows(tile_rows), .busy(busy),
      .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .done(done), .overflow(overflow), .stray(stray)
   );

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] model(input logic [DW-1:0] d);
      logic [DW-1:0] r = d;
`ifdef DRAIN_RELU_EN
      for (int i = 0; i < COLS; i++)
         if (d[AW*i+AW-1]) r[AW*i +: AW] = '0;
`endif
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_row();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   always @(negedge clk)
      if (!rst && out_valid && out_ready) begin
         out_rows++;
         check("row_expected", DW'(q_data.size() != 0), 1);
         if (q_data.size() != 0) begin
            check("row_data", out_data, model(q_data.pop_front()));
            check("row_last", out_last, q_last.pop_front());
         end
      end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_tile(input int n);
      cyc();
      start = 1'b1;
      tile_rows = 8'(n);
      cyc();
      start = 1'b0;
      base = out_rows;
   endtask

   task automatic send(input logic [DW-1:0] d, input bit keep, input bit last);
      cyc();
      in_valid = 1'b1;
      in_data = d;
      if (keep) begin
         q_data.push_back(d);
         q_last.push_back(last);
      end
   endtask

   task automatic idle_in();
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 200);
      check(tag, done, 1);
      @(negedge clk);
      check({tag, "_pulse"}, done, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      logic [DW-1:0] r;
      rst = 1'b1; start = 1'b0; tile_rows = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_done", done, 0);
      check("rst_overflow", overflow, 0);
      check("rst_stray", stray, 0);

      out_ready = 1'b1;
      begin_tile(4);
      @(negedge clk);
      check("t1_busy", busy, 1);
      for (int i = 0; i < 4; i++) begin
         send(rand_row(), 1, i == 3);
         if (i == 0) check("t1_lat0", out_valid, 0);
         if (i == 1) check("t1_lat1", out_valid, 1);
      end
      idle_in();
      wait_done("t1_done");
      check("t1_overflow", overflow, 0);
      check("t1_rows", out_rows - base, 4);

      out_ready = 1'b0;
      begin_tile(10);
      for (int i = 0; i < 10; i++) send(rand_row(), i < 8, i == 7);
      idle_in();
      @(negedge clk);
      check("t2_overflow", overflow, 1);
      check("t2_busy", busy, 1);
      check("t2_out_valid", out_valid, 1);
      check("t2_out_last", out_last, 0);
      check("t2_stall_data", out_data, model(q_data[0]));
      repeat (2) @(negedge clk);
      check("t2_stall_data2", out_data, model(q_data[0]));
      cyc();
      out_ready = 1'b1;
      wait_done("t2_done");
      check("t2_rows", out_rows - base, 8);
      check("t2_overflow_sticky", overflow, 1);

      out_ready = 1'b0;
      begin_tile(9);
      @(negedge clk);
      check("t3_overflow_clr", overflow, 0);
      for (int i = 0; i < 9; i++) begin
         send(rand_row(), 1, i == 8);
         if (i == 8) out_ready = 1'b1;
      end
      idle_in();
      wait_done("t3_done");
      check("t3_overflow", overflow, 0);
      check("t3_rows", out_rows - base, 9);

      begin_tile(0);
      @(negedge clk);
      check("t4_done", done, 1);
      check("t4_busy", busy, 0);
      check("t4_out_valid", out_valid, 0);
      @(negedge clk);
      check("t4_done_pulse", done, 0);
      check("t4_busy2", busy, 0);

      begin_tile(2);
      send(rand_row(), 1, 0);
      send(rand_row(), 1, 1);
      send(rand_row(), 0, 0);
      idle_in();
      wait_done("t5_done");
      check("t5_stray", stray, 1);
      check("t5_rows", out_rows - base, 2);

      begin_tile(1);
      @(negedge clk);
      check("t6_stray_clr", stray, 0);
      for (int i = 0; i < COLS; i++) r[AW*i +: AW] = (i % 2 != 0) ? 8'h07 : 8'hFB;
      send(r, 1, 1);
      idle_in();
      @(negedge clk);
`ifdef DRAIN_RELU_EN
      check("t6_e0", out_data[7:0], 8'h00);
`else
      check("t6_e0", out_data[7:0], 8'hFB);
`endif
      check("t6_e1", out_data[15:8], 8'h07);
      wait_done("t6_done");

      out_ready = 1'b0;
      begin_tile(4);
      send(rand_row(), 0, 0);
      send(rand_row(), 0, 0);
      idle_in();
      @(negedge clk);
      check("t7_out_valid", out_valid, 1);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("t7_rst_out_valid", out_valid, 0);
      check("t7_rst_busy", busy, 0);
      check("t7_rst_out_data", out_data, 0);
      out_ready = 1'b1;
      begin_tile(3);
      for (int i = 0; i < 3; i++) send(rand_row(), 1, i == 2);
      idle_in();
      wait_done("t7_done");
      check("t7_rows", out_rows - base, 3);
      check("queue_empty", q_data.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/acc_drain_buffer.md
# acc_drain_buffer

Downstream neighbour of the output deskew staging memory: accepts the deskewed accumulator rows of one PE block and buffers them in a row FIFO. It releases the rows to the output writer over a valid/ready stream and frames each tile with a last marker and a done pulse. The systolic array cannot stall, so the input side has no backpressure; overflow is detected and flagged instead.

## Interface
Parameters:
- acc_width, 8, bits per accumulator element (signed two's complement)
- systolic_column, 16, elements per row
- fifo_depth, 8, rows of buffering; power of two, ≥2
- row_cnt_width, 8, width of tile row counters

Ports:
- clk  input  1  single clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a tile; sampled only in IDLE
- tile_rows  input  row_cnt_width  rows in the tile; sampled with start
- busy  output  1  high in COLLECT
- in_valid  input  1  aligned row present on in_data
- in_data  input  acc_width*systolic_column  row; element i at bits [acc_width*(i+1)-1 : acc_width*i]
- out_valid  output  1  out_data holds a row
- out_ready  input  1  downstream accepts
- out_data  output  acc_width*systolic_column  row (element layout as in_data)
- out_last  output  1  qualifies the final row of the tile
- done  output  1  one-cycle pulse after the final row is handshaken out
- overflow  output  1  sticky: a row arrived while the FIFO was full
- stray  output  1  sticky: in_valid outside COLLECT, or beyond tile_rows

## Operation
- States: IDLE, COLLECT, DONE.
- IDLE: start=1 latches tile_rows into rows_q and clears in_cnt, out_cnt, overflow, stray.
  - rows_q≠0 → COLLECT.
  - rows_q=0 → DONE.
- COLLECT: push when in_valid=1 and in_cnt<rows_q. A push is accepted if the FIFO is not full, or is full with a pop in the same cycle. An accepted push increments in_cnt.
  - Push refused for fullness → row dropped, overflow=1, in_cnt still increments, so the tile length is preserved.
  - in_valid with in_cnt=rows_q → ignored, stray=1.
- Pop: out_valid = FIFO not empty; out_data = head entry. A handshake (out_valid & out_ready) pops and increments out_cnt.
- out_last = out_valid & (out_cnt == rows_q−1−dropped), where dropped counts overflow-dropped rows. The final surviving row is therefore always marked.
- When the final row handshakes, or in_cnt=rows_q with the FIFO empty and every row dropped → DONE.
- DONE: done=1 for exactly this one cycle, then → IDLE.
- in_valid in IDLE or DONE → ignored, stray=1.
- start outside IDLE → ignored.
- Counters are row_cnt_width wide; tile_rows is at most 2^row_cnt_width−1, so no wrap occurs within a tile.
- FIFO pointers are log2(fifo_depth) bits and wrap modulo fifo_depth. Occupancy counter is log2(fifo_depth)+1 bits.

## Timing
- Row pushed at edge t → out_valid at t+1 at the earliest. Registered FIFO, no combinational bypass from in_data to out_data.
- out_data and out_last are stable while out_valid=1 and out_ready=0.
- Sustained throughput is one row per cycle with out_ready held high.
- Reset values: busy=0, out_valid=0, out_data=0, out_last=0, done=0, overflow=0, stray=0; state=IDLE, FIFO empty.
- rst mid-tile discards all buffered rows. Outputs return to their reset values on the next edge.
- overflow and stray stay set until the next accepted start, or until rst.

## Configuration
- DRAIN_RELU_EN defined: each output element is max(element, 0), signed compare, applied combinationally between the FIFO head and out_data. Buffered contents are unchanged.
- DRAIN_RELU_EN undefined: out_data equals the FIFO head bit-exact.

## Test plan
- tile_rows=4, four consecutive in_valid rows, out_ready=1 → rows appear in order one cycle after each push; out_last on the 4th; done pulses the cycle after; overflow=0.
- fifo_depth=8, tile_rows=10, out_ready=0, 10 pushes → 8 rows buffered, overflow=1. Releasing out_ready drains 8 rows with out_last on the 8th, then done.
- FIFO full with pop and push in the same cycle → push accepted; occupancy stays 8; overflow stays 0.
- tile_rows=0 with start → done pulse the cycle after start; no out_valid; busy never 1.
- tile_rows=2 with 3 in_valid rows → 2 rows output, stray=1. A later start clears stray.
- DRAIN_RELU_EN, element values −5/+7 (0xFB/0x07 at acc_width=8) → out_data 0x00/0x07. Without the macro → 0xFB/0x07.
